calc: RTL and testbench

CALC -- requirements
Module: calc

---
 rtl/calc_pkg.sv | 12 +
 rtl/calc.sv | 52 +++++
 tb/tb_calc.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// calc_pkg -- shared project constants for the binarised-network datapath.
//   CALC_ALU_WIDTH : default accumulator width for calc
//   LAYER*_LEN     : number of product bits accumulated per neuron in each layer
package calc_pkg;

    localparam int unsigned CALC_ALU_WIDTH = 12;

    localparam int unsigned LAYER1_LEN = 784;
    localparam int unsigned LAYER2_LEN = 1024;
    localparam int unsigned LAYER3_LEN = 10;

endpackage : calc_pkg

// File: rtl/calc.sv
// calc -- saturating up/down accumulator for binarised dot products.
// Each enabled cycle consumes one XNOR-style product bit: 0 (match) counts up,
// 1 (mismatch) counts down. The signed sum saturates at its extremes.
// Ports:
//   clk           : clock, rising-edge active
//   rst           : asynchronous active-high reset, clears the accumulator
//   calc_1        : accumulate enable
//   calc_in       : product bit, 0 = +1, 1 = -1
//   agg_out2alu   : signed accumulator value (register output, no extra stage)
//   agg_out_acted : sign activation, 1 when accumulator >= 0
module calc
    import calc_pkg::*;
#(
    parameter int unsigned alu_width = CALC_ALU_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 calc_1,
    input  logic                 calc_in,
    output logic [alu_width-1:0] agg_out2alu,
    output logic                 agg_out_acted
);

    localparam logic [alu_width-1:0] ACC_MAX = {1'b0, {(alu_width-1){1'b1}}};
    localparam logic [alu_width-1:0] ACC_MIN = {1'b1, {(alu_width-1){1'b0}}};
    localparam logic [alu_width-1:0] ACC_ONE = {{(alu_width-1){1'b0}}, 1'b1};

    logic [alu_width-1:0] acc_q;
    logic [alu_width-1:0] acc_d;

    // Saturation is checked against the extremes before stepping, so the
    // adder never wraps.
    always_comb begin
        acc_d = acc_q;
        if (calc_1) begin
            if (!calc_in) begin
                if (acc_q != ACC_MAX) acc_d = acc_q + ACC_ONE;
            end else begin
                if (acc_q != ACC_MIN) acc_d = acc_q - ACC_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign agg_out2alu   = acc_q;
    assign agg_out_acted = ~acc_q[alu_width-1];

endmodule : calc

// File: tb/tb_calc.sv
// tb_calc -- directed self-checking bench for calc at the default width (12).
module tb_calc;

    localparam int unsigned W = 12;

    logic         clk;
    logic         rst;
    logic         calc_1;
    logic         calc_in;
    logic [W-1:0] agg_out2alu;
    logic         agg_out_acted;

    int unsigned n_checks;
    int unsigned n_fail;
    logic        sampled_acted;

    calc #(.alu_width(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .calc_1       (calc_1),
        .calc_in      (calc_in),
        .agg_out2alu  (agg_out2alu),
        .agg_out_acted(agg_out_acted)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic en, input logic bit_in);
        @(negedge clk);
        calc_1  = en;
        calc_in = bit_in;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int unsigned n, input logic en, input logic bit_in);
        for (int unsigned i = 0; i < n; i++) step(en, bit_in);
    endtask

    task automatic check_acc(input string tag, input logic [W-1:0] exp_acc, input logic exp_act);
        check({tag, "_acc"}, {20'd0, agg_out2alu}, {20'd0, exp_acc});
        check({tag, "_act"}, {31'd0, agg_out_acted}, {31'd0, exp_act});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        calc_1   = 1'b1;
        calc_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_acc("reset_held", 12'h000, 1'b1);
        @(negedge clk);
        rst    = 1'b0;
        calc_1 = 1'b0;
        @(posedge clk);
        #1;
        check_acc("reset_release", 12'h000, 1'b1);

        // Count up 5, then down 8; activation drops on the step to -1.
        run(5, 1'b1, 1'b0);
        check_acc("up5", 12'h005, 1'b1);
        run(5, 1'b1, 1'b1);
        check_acc("down_to_0", 12'h000, 1'b1);
        step(1'b1, 1'b1);
        check_acc("down_to_m1", 12'hFFF, 1'b0);
        run(2, 1'b1, 1'b1);
        check_acc("down_to_m3", 12'hFFD, 1'b0);

        // Enable low: acc holds at 2 under toggling calc_in.
        run(5, 1'b1, 1'b0);
        check_acc("up_to_2", 12'h002, 1'b1);
        for (int unsigned i = 0; i < 10; i++) step(1'b0, i[0]);
        check_acc("hold_disabled", 12'h002, 1'b1);

        // Asynchronous reset between edges takes effect immediately.
        #2;
        rst = 1'b1;
        #1;
        check_acc("async_reset", 12'h000, 1'b1);
        // Reset wins over a simultaneous up-count.
        @(negedge clk);
        calc_1  = 1'b1;
        calc_in = 1'b0;
        @(posedge clk);
        #1;
        check_acc("reset_priority", 12'h000, 1'b1);
        @(negedge clk);
        rst    = 1'b0;
        calc_1 = 1'b0;
        step(1'b1, 1'b0);
        check_acc("resume_after_reset", 12'h001, 1'b1);

        // Saturation at both extremes.
        run(2100, 1'b1, 1'b0);
        check_acc("sat_max", 12'h7FF, 1'b1);
        run(4200, 1'b1, 1'b1);
        check_acc("sat_min", 12'h800, 1'b0);
        step(1'b1, 1'b1);
        check_acc("sat_min_hold", 12'h800, 1'b0);
        step(1'b1, 1'b0);
        check_acc("leave_min", 12'h801, 1'b0);

        // Reset registered from a flop: a same-edge reader sees the pre-reset value.
        @(negedge clk);
        calc_1 = 1'b0;
        @(posedge clk);
        sampled_acted = agg_out_acted;
        rst <= 1'b1;
        #1;
        check("flop_rst_pre_value", {31'd0, sampled_acted}, 32'd0);
        check_acc("flop_rst_post", 12'h000, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        // Full layer of 1024 inputs, balanced matches and mismatches.
        for (int unsigned i = 0; i < 1024; i++) step(1'b1, i[0]);
        check_acc("layer_balanced", 12'h000, 1'b1);
        run(3, 1'b1, 1'b1);
        check_acc("partial_sum", 12'hFFD, 1'b0);
        @(negedge clk);
        calc_1 = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_acc("layer_rst_pulse", 12'h000, 1'b1);
        run(2, 1'b1, 1'b0);
        check_acc("layer_restart", 12'h002, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_calc
